// File: rtl/sdram_avs_bridge.sv
// -----------------------------------------------------------------------------
// sdram_avs_bridge
//   Avalon-MM slave front end of the SDRAM controller. Accepted Avalon
//   transfers are queued in a small request FIFO and presented to the SDRAM
//   access engine on a valid/ready channel. Reads are counted from acceptance
//   until their engine response returns, and responses are replayed to Avalon
//   as in-order readdatavalid pulses one clock after the engine delivers them.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   avs_*                 Avalon-MM slave (pipelined reads, waitrequest stall)
//   bus_req_*             request channel to the access engine (head of FIFO)
//   bus_resp_*            single-cycle read responses from the engine
//   err_flag              sticky protocol error (read+write together, or a
//                         response with no read outstanding)
// -----------------------------------------------------------------------------
module sdram_avs_bridge #(
   parameter int AVS_DW     = 16,
   parameter int AVS_AW     = 25,
   parameter int FIFO_DEPTH = 4,
   parameter int MAX_RD     = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  avs_read,
   input  logic                  avs_write,
   input  logic [AVS_AW-1:0]     avs_address,
   input  logic [AVS_DW-1:0]     avs_writedata,
   input  logic [AVS_DW/8-1:0]   avs_byteenable,
   output logic                  avs_waitrequest,
   output logic [AVS_DW-1:0]     avs_readdata,
   output logic                  avs_readdatavalid,
   output logic                  bus_req_valid,
   input  logic                  bus_req_ready,
   output logic                  bus_req_write,
   output logic [AVS_AW-1:0]     bus_req_address,
   output logic [AVS_DW-1:0]     bus_req_writedata,
   output logic [AVS_DW/8-1:0]   bus_req_byteenable,
   input  logic                  bus_resp_valid,
   input  logic [AVS_DW-1:0]     bus_resp_readdata,
   output logic                  err_flag
);

   localparam int AVS_BYTE = AVS_DW / 8;
   localparam int PTR_W    = $clog2(FIFO_DEPTH);
   localparam int ENTRY_W  = 1 + AVS_AW + AVS_DW + AVS_BYTE;

   localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);
   localparam logic [7:0]     RD_LIMIT   = 8'(MAX_RD);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

   // Request storage: {write, address, writedata, byteenable}.
   logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic [7:0]       rd_outstanding_q, rd_outstanding_d;
   logic             err_flag_q, err_flag_d;
   logic             readdatavalid_q, readdatavalid_d;
   logic [AVS_DW-1:0] readdata_q, readdata_d;

   logic fifo_full, fifo_empty;
   logic avs_accept, rd_accept, fifo_pop, resp_ok;

   assign fifo_full  = (count_q == FULL_COUNT);
   assign fifo_empty = (count_q == '0);

   // A write never waits on the read limit; only a pure read does.
   assign avs_waitrequest = reset | fifo_full |
                            (avs_read & ~avs_write & (rd_outstanding_q == RD_LIMIT));

   assign avs_accept = (avs_read | avs_write) & ~avs_waitrequest;
   // Read+write together is queued as a write only, so it is not counted.
   assign rd_accept  = avs_accept & avs_read & ~avs_write;
   assign fifo_pop   = bus_req_valid & bus_req_ready;
   assign resp_ok    = bus_resp_valid & (rd_outstanding_q != 8'd0);

   // Head entry drives the engine directly; it cannot change while valid and
   // not ready because only a pop moves rd_ptr.
   assign bus_req_valid = ~fifo_empty;
   assign {bus_req_write, bus_req_address, bus_req_writedata, bus_req_byteenable} =
          mem_q[rd_ptr_q];

   assign avs_readdatavalid = readdatavalid_q;
   assign avs_readdata      = readdata_q;
   assign err_flag          = err_flag_q;

   always_comb begin
      // NOTE: every variable gets a default before any conditional update so
      // that no path leaves it unassigned and no latch is inferred.
      wr_ptr_d         = wr_ptr_q;
      rd_ptr_d         = rd_ptr_q;
      count_d          = count_q;
      rd_outstanding_d = rd_outstanding_q;
      err_flag_d       = err_flag_q;
      readdatavalid_d  = resp_ok;
      readdata_d       = readdata_q;

      if (avs_accept) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (fifo_pop)   rd_ptr_d = rd_ptr_q + PTR_ONE;

      case ({avs_accept, fifo_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      case ({rd_accept, resp_ok})
         2'b10:   rd_outstanding_d = rd_outstanding_q + 8'd1;
         2'b01:   rd_outstanding_d = rd_outstanding_q - 8'd1;
         default: rd_outstanding_d = rd_outstanding_q;
      endcase

      if (resp_ok) readdata_d = bus_resp_readdata;

      if ((avs_accept & avs_read & avs_write) |
          (bus_resp_valid & (rd_outstanding_q == 8'd0)))
         err_flag_d = 1'b1;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples its _d value from before the edge, independent of block order.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q         <= '0;
         rd_ptr_q         <= '0;
         count_q          <= '0;
         rd_outstanding_q <= 8'd0;
         err_flag_q       <= 1'b0;
         readdatavalid_q  <= 1'b0;
         readdata_q       <= '0;
      end else begin
         wr_ptr_q         <= wr_ptr_d;
         rd_ptr_q         <= rd_ptr_d;
         count_q          <= count_d;
         rd_outstanding_q <= rd_outstanding_d;
         err_flag_q       <= err_flag_d;
         readdatavalid_q  <= readdatavalid_d;
         readdata_q       <= readdata_d;
      end
   end

   // NOTE: the storage array is deliberately not reset; an entry is only
   // read after it has been written, and the count alone defines validity.
   always_ff @(posedge clk) begin
      if (avs_accept)
         mem_q[wr_ptr_q] <= {avs_write, avs_address, avs_writedata, avs_byteenable};
   end

endmodule

// File: tb/tb_sdram_avs_bridge.sv
// -----------------------------------------------------------------------------
// tb_sdram_avs_bridge
//   Self-checking bench for sdram_avs_bridge. A negedge monitor pushes every
//   accepted Avalon transfer into an expected-request queue and compares it
//   against the engine-side handshake; read data expected from each engine
//   response is queued by the stimulus and compared on readdatavalid.
// -----------------------------------------------------------------------------
module tb_sdram_avs_bridge;

   localparam int DW = 16;
   localparam int AW = 25;
   localparam int BW = DW / 8;

   typedef struct packed {
      logic          wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic [BW-1:0] be;
   } req_t;

   logic          clk = 1'b0;
   logic          reset;
   logic          avs_read, avs_write;
   logic [AW-1:0] avs_address;
   logic [DW-1:0] avs_writedata;
   logic [BW-1:0] avs_byteenable;
   logic          avs_waitrequest;
   logic [DW-1:0] avs_readdata;
   logic          avs_readdatavalid;
   logic          bus_req_valid, bus_req_ready, bus_req_write;
   logic [AW-1:0] bus_req_address;
   logic [DW-1:0] bus_req_writedata;
   logic [BW-1:0] bus_req_byteenable;
   logic          bus_resp_valid;
   logic [DW-1:0] bus_resp_readdata;
   logic          err_flag;

   int vectors = 0;
   int miscompares = 0;

   req_t          exp_req[$];
   logic [DW-1:0] exp_rd[$];

   sdram_avs_bridge #(.AVS_DW(DW), .AVS_AW(AW), .FIFO_DEPTH(4), .MAX_RD(4)) dut (
      .clk                (clk),
      .reset              (reset),
      .avs_read           (avs_read),
      .avs_write          (avs_write),
      .avs_address        (avs_address),
      .avs_writedata      (avs_writedata),
      .avs_byteenable     (avs_byteenable),
      .avs_waitrequest    (avs_waitrequest),
      .avs_readdata       (avs_readdata),
      .avs_readdatavalid  (avs_readdatavalid),
      .bus_req_valid      (bus_req_valid),
      .bus_req_ready      (bus_req_ready),
      .bus_req_write      (bus_req_write),
      .bus_req_address    (bus_req_address),
      .bus_req_writedata  (bus_req_writedata),
      .bus_req_byteenable (bus_req_byteenable),
      .bus_resp_valid     (bus_resp_valid),
      .bus_resp_readdata  (bus_resp_readdata),
      .err_flag           (err_flag)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_resp(input logic [DW-1:0] data);
      bus_resp_valid    = 1'b1;
      bus_resp_readdata = data;
      exp_rd.push_back(data);
   endtask

   // Monitor, sampled mid-cycle while inputs are stable.
   always @(negedge clk) begin
      if (!reset) begin
         if ((avs_read | avs_write) & ~avs_waitrequest)
            exp_req.push_back('{wr: avs_write, addr: avs_address,
                                data: avs_writedata, be: avs_byteenable});
         if (bus_req_valid & bus_req_ready) begin
            if (exp_req.size() == 0)
               check("req_unexpected", 1, 0);
            else
               check("req_fields",
                     {20'd0, bus_req_write, bus_req_address, bus_req_writedata, bus_req_byteenable},
                     {20'd0, exp_req.pop_front()});
         end
         if (avs_readdatavalid) begin
            if (exp_rd.size() == 0)
               check("rdv_unexpected", 1, 0);
            else
               check("readdata", avs_readdata, exp_rd.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; avs_read = 1'b0; avs_write = 1'b0;
      avs_address = '0; avs_writedata = '0; avs_byteenable = '0;
      bus_req_ready = 1'b0; bus_resp_valid = 1'b0; bus_resp_readdata = '0;

      // Reset then idle.
      for (int i = 0; i < 3; i++) begin
         tick();
         check("rst_waitreq", avs_waitrequest, 1);
      end
      check("rst_req_valid", bus_req_valid, 0);
      check("rst_rdv", avs_readdatavalid, 0);
      check("rst_readdata", avs_readdata, 0);
      check("rst_err", err_flag, 0);
      reset = 1'b0;
      #1 check("post_rst_waitreq", avs_waitrequest, 0);

      // Single write.
      bus_req_ready = 1'b1;
      avs_write = 1'b1; avs_address = 25'h0000120; avs_writedata = 16'hBEEF; avs_byteenable = 2'b11;
      #1 check("wr_waitreq", avs_waitrequest, 0);
      check("wr_no_bypass", bus_req_valid, 0);
      tick();
      avs_write = 1'b0;
      #1;
      check("wr_req_valid", bus_req_valid, 1);
      check("wr_req_write", bus_req_write, 1);
      check("wr_req_addr", bus_req_address, 25'h120);
      check("wr_req_data", bus_req_writedata, 16'hBEEF);
      check("wr_req_be", bus_req_byteenable, 2'b11);
      tick();
      check("wr_fifo_empty", bus_req_valid, 0);
      check("wr_no_rdv", avs_readdatavalid, 0);

      // FIFO full backpressure.
      bus_req_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         avs_write = 1'b1; avs_address = AW'(2 * i);
         avs_writedata = 16'hA000 + 16'(i); avs_byteenable = 2'b10;
         #1 check("fill_waitreq", avs_waitrequest, 0);
         tick();
      end
      avs_address = 25'h8; avs_writedata = 16'hA004;
      #1 check("full_waitreq", avs_waitrequest, 1);
      check("full_head_addr", bus_req_address, 25'h0);
      avs_write = 1'b0;
      bus_req_ready = 1'b1;
      tick();
      check("pop1_waitreq", avs_waitrequest, 0);
      check("pop1_head_addr", bus_req_address, 25'h2);
      tick(); tick(); tick();
      check("drain_empty", bus_req_valid, 0);

      // Read limit.
      for (int i = 0; i < 4; i++) begin
         avs_read = 1'b1; avs_address = 25'h100 + AW'(2 * i);
         avs_writedata = 16'h0055; avs_byteenable = 2'b01;
         #1 check("rd_waitreq", avs_waitrequest, 0);
         tick();
      end
      avs_address = 25'h108;
      #1 check("rd_limit_waitreq", avs_waitrequest, 1);
      avs_read = 1'b0;
      avs_write = 1'b1; avs_address = 25'h200; avs_writedata = 16'h1111; avs_byteenable = 2'b11;
      #1 check("wr_past_limit", avs_waitrequest, 0);
      tick();
      avs_write = 1'b0;
      avs_read = 1'b1; avs_address = 25'h108;
      send_resp(16'h1234);
      #1 check("rd_limit_hold", avs_waitrequest, 1);
      tick();
      bus_resp_valid = 1'b0;
      #1;
      check("resp_rdv", avs_readdatavalid, 1);
      check("resp_data", avs_readdata, 16'h1234);
      check("rd5_released", avs_waitrequest, 0);
      tick();
      avs_read = 1'b0;
      for (int i = 0; i < 4; i++) begin
         send_resp(16'h5000 + 16'(i));
         tick();
      end
      bus_resp_valid = 1'b0;
      tick();
      check("rdv_idle", avs_readdatavalid, 0);
      check("readdata_hold", avs_readdata, 16'h5003);
      check("rd_out_drained", dut.rd_outstanding_q, 0);

      // Simultaneous increment and decrement at two outstanding.
      avs_read = 1'b1; avs_address = 25'h400; tick();
      avs_address = 25'h402; tick();
      avs_address = 25'h404;
      send_resp(16'h7777);
      tick();
      bus_resp_valid = 1'b0;
      check("rd_out_simul", dut.rd_outstanding_q, 2);
      for (int i = 0; i < 2; i++) begin
         avs_address = 25'h406 + AW'(2 * i);
         #1 check("simul_rd_waitreq", avs_waitrequest, 0);
         tick();
      end
      avs_address = 25'h40A;
      #1 check("simul_limit", avs_waitrequest, 1);
      avs_read = 1'b0;
      for (int i = 0; i < 4; i++) begin
         send_resp(16'h6000 + 16'(i));
         tick();
      end
      bus_resp_valid = 1'b0;
      tick(); tick();
      check("no_err_yet", err_flag, 0);

      // Unexpected response.
      bus_resp_valid = 1'b1; bus_resp_readdata = 16'hDEAD;
      tick();
      bus_resp_valid = 1'b0;
      #1;
      check("unexp_no_rdv", avs_readdatavalid, 0);
      check("unexp_err", err_flag, 1);
      check("unexp_cnt", dut.rd_outstanding_q, 0);
      tick(); tick();
      check("err_sticky", err_flag, 1);

      // Reset clears the error.
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("rst_clears_err", err_flag, 0);

      // Read and write together.
      bus_req_ready = 1'b0;
      avs_read = 1'b1; avs_write = 1'b1;
      avs_address = 25'h300; avs_writedata = 16'hCAFE; avs_byteenable = 2'b01;
      #1 check("rw_waitreq", avs_waitrequest, 0);
      tick();
      avs_read = 1'b0; avs_write = 1'b0;
      #1;
      check("rw_err", err_flag, 1);
      check("rw_req_valid", bus_req_valid, 1);
      check("rw_req_write", bus_req_write, 1);
      check("rw_req_addr", bus_req_address, 25'h300);
      check("rw_no_rd_count", dut.rd_outstanding_q, 0);
      bus_req_ready = 1'b1;
      tick();
      check("rw_single_entry", bus_req_valid, 0);
      tick();

      check("req_queue_empty", exp_req.size(), 0);
      check("rd_queue_empty", exp_rd.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
